voq_scheduler: RTL

- Central crossbar scheduler for the 4-port switch.
- Each time slot, it takes the non-empty status of every ingress VOQ and computes a conflict-free ingress-to-egress matching with a sequential round-robin algorithm.
- For each matched ingress, it issues the VOQ to dequeue (sched_en/sched_sel).
- It drives the per-egress crossbar source selects for that slot.

---
 rtl/voq_scheduler_if.sv | 30 +++
 rtl/voq_scheduler.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/voq_scheduler_if.sv
// voq_scheduler_if: bundles the scheduler's slot-control, VOQ status, dequeue and crossbar-select signals.
// Latency: none; this is wiring only.
// Backpressure: none; the scheduler samples sched_enable only at slot boundaries.
// Modports: master drives sched_enable/voq_nonempty and observes the rest; slave is the scheduler.
interface voq_scheduler_if #(
  parameter int INGRESS_CNT = 4,
  parameter int EGRESS_CNT  = 4
);
  localparam int IW = $clog2(INGRESS_CNT);
  localparam int EW = $clog2(EGRESS_CNT);

  logic                               sched_enable;
  logic [INGRESS_CNT*EGRESS_CNT-1:0]  voq_nonempty;
  logic [INGRESS_CNT-1:0]             sched_en;
  logic [INGRESS_CNT*EW-1:0]          sched_sel;
  logic [EGRESS_CNT-1:0]              xbar_valid;
  logic [EGRESS_CNT*IW-1:0]           xbar_src;
  logic                               slot_start;
  logic                               busy;

  modport master (
    output sched_enable, voq_nonempty,
    input  sched_en, sched_sel, xbar_valid, xbar_src, slot_start, busy
  );

  modport slave (
    input  sched_enable, voq_nonempty,
    output sched_en, sched_sel, xbar_valid, xbar_src, slot_start, busy
  );
endinterface

// File: rtl/voq_scheduler.sv
// voq_scheduler: per-slot sequential round-robin ingress->egress matching for the crossbar.
// Latency: SNAP to ISSUE is INGRESS_CNT+1 cycles; one slot every SLOT_CYCLES cycles.
// Backpressure: none; sched_enable only gates the start of the next slot, it never aborts one.
// Ports: clk; reset (async, active-low); sif.slave carries sched_enable/voq_nonempty in and
//        sched_en/sched_sel/xbar_valid/xbar_src/slot_start/busy out (all outputs registered).
module voq_scheduler #(
  parameter int INGRESS_CNT = 4,
  parameter int EGRESS_CNT  = 4,
  parameter int SLOT_CYCLES = 8
) (
  input  logic           clk,
  input  logic           reset,
  voq_scheduler_if.slave sif
);
  localparam int IW = $clog2(INGRESS_CNT);
  localparam int EW = $clog2(EGRESS_CNT);
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic [IW:0] IN_CNT = (IW+1)'(INGRESS_CNT);

  typedef enum logic [2:0] {IDLE, SNAP, MATCH, ISSUE, WAIT} state_t;

  state_t                                  state_q, state_d;
  logic [CW-1:0]                           slot_cnt_q, slot_cnt_d;
  logic [IW-1:0]                           rr_in_q, rr_in_d;
  logic [INGRESS_CNT-1:0][EW-1:0]          eg_ptr_q, eg_ptr_d;
  logic [INGRESS_CNT-1:0][EGRESS_CNT-1:0]  snap_q, snap_d;
  logic [EGRESS_CNT-1:0]                   matched_eg_q, matched_eg_d;
  logic [INGRESS_CNT-1:0]                  match_vld_q, match_vld_d;
  logic [INGRESS_CNT-1:0][EW-1:0]          match_eg_q, match_eg_d;

  logic [INGRESS_CNT-1:0]                  sched_en_q, sched_en_d;
  logic [INGRESS_CNT-1:0][EW-1:0]          sched_sel_q, sched_sel_d;
  logic [EGRESS_CNT-1:0]                   xbar_valid_q, xbar_valid_d;
  logic [EGRESS_CNT-1:0][IW-1:0]           xbar_src_q, xbar_src_d;
  logic                                    slot_start_q, slot_start_d;
  logic                                    busy_q, busy_d;

  logic [IW:0]   in_sum;
  logic [IW-1:0] k_in;
  logic [IW-1:0] cur_in;
  logic [EW-1:0] cand;
  logic [EW-1:0] pick;
  logic          found;
  logic          slot_end;

  // Ingress under consideration this MATCH cycle and its first free requested egress,
  // scanning from that ingress's round-robin pointer.
  always_comb begin
    k_in   = (state_q == MATCH) ? IW'(slot_cnt_q - CW'(1)) : '0;
    in_sum = {1'b0, rr_in_q} + {1'b0, k_in};
    if (in_sum >= IN_CNT) begin
      in_sum = in_sum - IN_CNT;
    end
    cur_in = in_sum[IW-1:0];
    found  = 1'b0;
    pick   = '0;
    cand   = '0;
    for (int m = 0; m < EGRESS_CNT; m++) begin
      cand = eg_ptr_q[cur_in] + EW'(m);
      if (!found && snap_q[cur_in][cand] && !matched_eg_q[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    slot_cnt_d   = slot_cnt_q;
    rr_in_d      = rr_in_q;
    eg_ptr_d     = eg_ptr_q;
    snap_d       = snap_q;
    matched_eg_d = matched_eg_q;
    match_vld_d  = match_vld_q;
    match_eg_d   = match_eg_q;
    sched_en_d   = '0;
    sched_sel_d  = sched_sel_q;
    xbar_valid_d = xbar_valid_q;
    xbar_src_d   = xbar_src_q;
    slot_start_d = 1'b0;
    slot_end     = ((state_q == ISSUE) || (state_q == WAIT)) &&
                   (slot_cnt_q == CW'(SLOT_CYCLES - 1));

    unique case (state_q)
      IDLE: begin
        if (sif.sched_enable) begin
          state_d      = SNAP;
          slot_start_d = 1'b1;
        end
      end
      SNAP: begin
        snap_d       = sif.voq_nonempty;
        matched_eg_d = '0;
        match_vld_d  = '0;
        state_d      = MATCH;
        slot_cnt_d   = CW'(1);
      end
      MATCH: begin
        slot_cnt_d = slot_cnt_q + CW'(1);
        if (found) begin
          match_vld_d[cur_in] = 1'b1;
          match_eg_d[cur_in]  = pick;
          matched_eg_d[pick]  = 1'b1;
        end
        // The last ingress's decision is folded in here so the issue outputs are
        // registered and visible exactly during the ISSUE cycle.
        if (slot_cnt_q == CW'(INGRESS_CNT)) begin
          state_d      = ISSUE;
          xbar_valid_d = '0;
          for (int i = 0; i < INGRESS_CNT; i++) begin
            if (match_vld_d[i]) begin
              sched_en_d[i]                = 1'b1;
              sched_sel_d[i]               = match_eg_d[i];
              xbar_valid_d[match_eg_d[i]]  = 1'b1;
              xbar_src_d[match_eg_d[i]]    = IW'(i);
            end
          end
        end
      end
      ISSUE: begin
        for (int i = 0; i < INGRESS_CNT; i++) begin
          if (match_vld_q[i]) begin
            eg_ptr_d[i] = match_eg_q[i] + EW'(1);
          end
        end
        rr_in_d    = (rr_in_q == IW'(INGRESS_CNT - 1)) ? '0 : rr_in_q + IW'(1);
        state_d    = WAIT;
        slot_cnt_d = slot_cnt_q + CW'(1);
      end
      WAIT: begin
        slot_cnt_d = slot_cnt_q + CW'(1);
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // End of slot: chain straight into the next SNAP or fall back to IDLE.
    // Also covers ISSUE being the last cycle when SLOT_CYCLES == INGRESS_CNT+2.
    if (slot_end) begin
      slot_cnt_d = '0;
      if (sif.sched_enable) begin
        state_d      = SNAP;
        slot_start_d = 1'b1;
      end else begin
        state_d      = IDLE;
        xbar_valid_d = '0;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      slot_cnt_q   <= '0;
      rr_in_q      <= '0;
      eg_ptr_q     <= '0;
      snap_q       <= '0;
      matched_eg_q <= '0;
      match_vld_q  <= '0;
      match_eg_q   <= '0;
      sched_en_q   <= '0;
      sched_sel_q  <= '0;
      xbar_valid_q <= '0;
      xbar_src_q   <= '0;
      slot_start_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_cnt_q   <= slot_cnt_d;
      rr_in_q      <= rr_in_d;
      eg_ptr_q     <= eg_ptr_d;
      snap_q       <= snap_d;
      matched_eg_q <= matched_eg_d;
      match_vld_q  <= match_vld_d;
      match_eg_q   <= match_eg_d;
      sched_en_q   <= sched_en_d;
      sched_sel_q  <= sched_sel_d;
      xbar_valid_q <= xbar_valid_d;
      xbar_src_q   <= xbar_src_d;
      slot_start_q <= slot_start_d;
      busy_q       <= busy_d;
    end
  end

  assign sif.sched_en   = sched_en_q;
  assign sif.sched_sel  = sched_sel_q;
  assign sif.xbar_valid = xbar_valid_q;
  assign sif.xbar_src   = xbar_src_q;
  assign sif.slot_start = slot_start_q;
  assign sif.busy       = busy_q;
endmodule
